// File: rtl/reg_access_ctrl_if.sv
// reg_access_ctrl_if: request/acknowledge bus between a requester (master) and reg_access_ctrl (slave)
interface reg_access_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req_vld;
  logic                  req_rdy;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wr;
  logic [DATA_WIDTH-1:0] req_wr_data;
  logic                  ack_vld;
  logic                  ack_rdy;
  logic [DATA_WIDTH-1:0] ack_rd_data;
  logic                  ack_err;
  modport master (
    output req_vld, req_addr, req_wr, req_wr_data, ack_rdy,
    input  req_rdy, ack_vld, ack_rd_data, ack_err
  );
  modport slave (
    input  req_vld, req_addr, req_wr, req_wr_data, ack_rdy,
    output req_rdy, ack_vld, ack_rd_data, ack_err
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: IDLE/ACCESS/ACK register access FSM with one-cycle sw strobes;
// define REG_ACCESS_ERR_EN to report unmapped addresses on ack_err.
module reg_access_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sync_rst,
  reg_access_ctrl_if.slave              bus,
  output logic [REG_NUM-1:0]            sw_rd,
  output logic [REG_NUM-1:0]            sw_wr,
  output logic [DATA_WIDTH-1:0]         sw_wr_data,
  input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rd_data
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2;
  localparam int BYTES = DATA_WIDTH / 8;
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q, off;
  logic                  wr_q, hit, go;
  logic [REG_NUM-1:0]    sel;
  logic [DATA_WIDTH-1:0] rd_mux, rd_q;
  assign off = addr_q - ADDR_WIDTH'(BASE_ADDR);
  assign hit = addr_q >= ADDR_WIDTH'(BASE_ADDR) && {1'b0, off} < (ADDR_WIDTH+1)'(REG_NUM * BYTES)
               && off % ADDR_WIDTH'(BYTES) == '0;
  always_comb begin
    sel = '0;
    rd_mux = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      sel[i] = hit && off == ADDR_WIDTH'(i * BYTES);
      rd_mux = rd_mux | (sel[i] ? reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
  end
  // sync_rst in the ACCESS cycle must suppress the strobe, so gate it combinationally
  assign go    = state == ACCESS && !sync_rst;
  assign sw_wr = go && wr_q ? sel : '0;
  assign sw_rd = go && !wr_q ? sel : '0;
  assign bus.req_rdy     = state == IDLE;
  assign bus.ack_vld     = state == ACK;
  assign bus.ack_rd_data = rd_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      sw_wr_data <= '0;
      rd_q       <= '0;
    end else if (sync_rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      sw_wr_data <= '0;
      rd_q       <= '0;
    end else if (state == IDLE) begin
      if (bus.req_vld) begin
        state      <= ACCESS;
        addr_q     <= bus.req_addr;
        wr_q       <= bus.req_wr;
        sw_wr_data <= bus.req_wr_data;
      end
    end else if (state == ACCESS) begin
      state <= ACK;
      rd_q  <= wr_q ? '0 : rd_mux;
    end else if (bus.ack_rdy)
      state <= IDLE;
`ifdef REG_ACCESS_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (sync_rst) err_q <= 1'b0;
    else if (state == ACCESS) err_q <= !hit;
  assign bus.ack_err = err_q;
`else
  assign bus.ack_err = 1'b0;
`endif
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: directed and randomized transactions checked against an address-decode reference model
module tb_reg_access_ctrl;
  localparam int AW = 16, DW = 32, RN = 4, BASE = 0, BYTES = DW / 8;
  logic clk = 1'b0, rst_n = 1'b0, sync_rst = 1'b0;
  logic [RN-1:0]    sw_rd, sw_wr;
  logic [DW-1:0]    sw_wr_data;
  logic [DW-1:0]    regs [RN];
  logic [RN*DW-1:0] reg_rd_data;
  int tests = 0, fails = 0;
  reg_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  reg_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUM(RN), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .sync_rst(sync_rst), .bus(bus),
    .sw_rd(sw_rd), .sw_wr(sw_wr), .sw_wr_data(sw_wr_data), .reg_rd_data(reg_rd_data)
  );
  always #5 clk = ~clk;
  always_comb begin
    reg_rd_data = '0;
    for (int i = 0; i < RN; i++) reg_rd_data[i*DW +: DW] = regs[i];
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference decode straight from the address map: byte offset, range, alignment
  function automatic void decode(input logic [AW-1:0] a, output logic h, output int idx);
    int off;
    off = int'(a) - BASE;
    h = off >= 0 && off < RN * BYTES && off % BYTES == 0;
    idx = h ? off / BYTES : 0;
  endfunction
  task automatic txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input int hold, input bit rc);
    logic h;
    int idx;
    logic [RN-1:0] oh;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    decode(a, h, idx);
    oh = h ? RN'(1) << idx : '0;
    exp_rd = (h && !w) ? regs[idx] : '0;
`ifdef REG_ACCESS_ERR_EN
    exp_err = !h;
`else
    exp_err = 1'b0;
`endif
    chk("req_rdy_idle", bus.req_rdy, 1);
    bus.req_vld = 1'b1; bus.req_addr = a; bus.req_wr = w; bus.req_wr_data = d;
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    chk("sw_wr", sw_wr, w ? oh : '0);
    chk("sw_rd", sw_rd, w ? '0 : oh);
    chk("sw_wr_data", sw_wr_data, d);
    chk("ack_early", bus.ack_vld, 0);
    chk("rdy_access", bus.req_rdy, 0);
    @(posedge clk); #1;
    if (rc && h && !w) regs[idx] = '0;
    for (int k = 0; k <= hold; k++) begin
      chk("ack_vld", bus.ack_vld, 1);
      chk("ack_rd_data", bus.ack_rd_data, exp_rd);
      chk("ack_err", bus.ack_err, exp_err);
      chk("rdy_ack", bus.req_rdy, 0);
      chk("no_strobe_ack", {sw_rd, sw_wr}, '0);
      if (k < hold) begin
        bus.req_vld = 1'b1; bus.req_addr = a ^ 16'h4; bus.req_wr = !w;
      end else begin
        bus.req_vld = 1'b0; bus.ack_rdy = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.ack_rdy = 1'b0;
    chk("ack_done", bus.ack_vld, 0);
    chk("rdy_after", bus.req_rdy, 1);
    chk("no_strobe_after", {sw_rd, sw_wr}, '0);
    chk("wr_data_hold", sw_wr_data, d);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.req_vld = 1'b0; bus.req_addr = '0; bus.req_wr = 1'b0; bus.req_wr_data = '0; bus.ack_rdy = 1'b0;
    for (int i = 0; i < RN; i++) regs[i] = $urandom;
    #1;
    chk("rst_req_rdy", bus.req_rdy, 1);
    chk("rst_ack_vld", bus.ack_vld, 0);
    chk("rst_ack_rd_data", bus.ack_rd_data, 0);
    chk("rst_ack_err", bus.ack_err, 0);
    chk("rst_sw", {sw_rd, sw_wr}, 0);
    chk("rst_sw_wr_data", sw_wr_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    regs[3] = 32'h12345678;
    txn(16'h0008, 1'b1, 32'hDEADBEEF, 0, 1'b0);
    txn(16'h000C, 1'b0, 32'h0, 0, 1'b1);
    chk("read_clear", regs[3], 0);
    txn(16'h0010, 1'b0, 32'h1111, 0, 1'b0);
    txn(16'h0005, 1'b0, 32'h2222, 0, 1'b0);
    txn(16'h0004, 1'b0, 32'h3333, 5, 1'b0);
    // sync reset in the ACCESS cycle drops the transaction
    bus.req_vld = 1'b1; bus.req_addr = 16'h0000; bus.req_wr = 1'b1; bus.req_wr_data = 32'hCAFE;
    @(posedge clk); #1;
    bus.req_vld = 1'b0; sync_rst = 1'b1;
    #1;
    chk("srst_no_strobe", {sw_rd, sw_wr}, 0);
    @(posedge clk); #1;
    sync_rst = 1'b0;
    chk("srst_ack_vld", bus.ack_vld, 0);
    chk("srst_req_rdy", bus.req_rdy, 1);
    chk("srst_wr_data", sw_wr_data, 0);
    @(posedge clk); #1;
    chk("srst_no_ack", bus.ack_vld, 0);
    // sync reset beats a same-cycle handshake
    sync_rst = 1'b1; bus.req_vld = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0; bus.req_vld = 1'b0;
    chk("srst_prio_rdy", bus.req_rdy, 1);
    chk("srst_prio_strobe", {sw_rd, sw_wr}, 0);
    // async reset while an ack is pending
    bus.req_vld = 1'b1; bus.req_addr = 16'h0004; bus.req_wr = 1'b1; bus.req_wr_data = 32'hBEEF;
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    @(posedge clk); #1;
    chk("arst_pre_ack", bus.ack_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack_vld", bus.ack_vld, 0);
    chk("arst_req_rdy", bus.req_rdy, 1);
    chk("arst_wr_data", sw_wr_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < RN; i++) regs[i] = $urandom;
      txn($urandom_range(0, 3) == 0 ? AW'($urandom) : AW'($urandom_range(0, 20)),
          1'($urandom), $urandom, $urandom_range(0, 3), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
